option_fifo_sched: RTL and testbench
====================================

// Module: option_fifo_sched
// PURPOSE
//  Owns the single option FIFO shared by the parser (loader) and the solver (reader / re-writer).
//  Sequences phases IDLE->LOAD->SOLVE->DRAIN and grants the write port to one requester per phase.
//  Gates read/write against FULL/EMPTY and keeps an exact occupancy count.
//  Tracks solver passes over the FIFO and flags a stalled (non-converging) board.
// PARAMETERS
//  WIDTH        16    option word width (FIFO din/dout)
//  DEPTH        1024  FIFO capacity in words
//  PASS_W       16    width of pass counter and per-pass word counters
//  STALL_PASSES 2     consecutive equal-length passes that raise stall
// PORTS
//  clk_100mhz    in   1                    system clock
//  rst           in   1                    sync reset, active-high
//  parse_wr      in   1                    parser write request
//  parse_din     in   WIDTH                parser option word
//  board_parsed  in   1                    pulse: parsing complete
//  solve_wr      in   1                    solver put-back request
//  solve_din     in   WIDTH                solver option word
//  solve_rd      in   1                    solver next-line (pop) request
//  board_solved  in   1                    pulse: solver done
//  assembled     in   1                    pulse: output transmitted
//  fifo_full     in   1                    FIFO full flag
//  fifo_empty    in   1                    FIFO empty flag
//  fifo_wr_en    out  1                    FIFO write enable
//  fifo_din      out  WIDTH                FIFO write data
//  fifo_rd_en    out  1                    FIFO read enable
//  phase         out  2                    0 IDLE, 1 LOAD, 2 SOLVE, 3 DRAIN
//  occupancy     out  $clog2(DEPTH+1)      words currently in FIFO
//  pass_count    out  PASS_W               completed solver passes
//  stall         out  1                    sticky: no convergence detected
//  overflow_err  out  1                    sticky: write dropped while full
// BEHAVIOUR
//  Reset: phase=IDLE; occupancy, pass_count, internal counters = 0; stall, overflow_err = 0.
//  rst clears only this block; the FIFO is cleared by its own srst on the same rst.
//  FSM (registered): IDLE->LOAD on first parse_wr; LOAD->SOLVE on board_parsed;
//   SOLVE->DRAIN on board_solved; DRAIN->IDLE on assembled. Other inputs ignored.
//  Write mux is combinational, zero latency: LOAD grants parse_*, SOLVE grants solve_*.
//   IDLE also grants parse_wr, so the first word is never lost. DRAIN grants none.
//   fifo_wr_en = granted_wr & ~fifo_full; fifo_din = granted din.
//  Read: fifo_rd_en = solve_rd & ~fifo_empty & (phase==SOLVE). A pop on empty is ignored, no error.
//  Write request while full: dropped, overflow_err<=1 (held until rst).
//  occupancy: +1 on accepted write only, -1 on accepted read only, unchanged on both or neither.
//   Never wraps; checked equal to FIFO contents.
//  board_parsed coincident with parse_wr: the write is accepted (LOAD rules), then SOLVE is entered.
//  Pass tracking: on SOLVE entry, pass_len <= occupancy and reads_left <= occupancy.
//   Each accepted read decrements reads_left; each accepted write increments pass_writes.
//   When reads_left hits 0 (same cycle as the last read), pass_count++.
//   If pass_writes==pass_len, same_cnt++; otherwise same_cnt<=0.
//   Then pass_len <= pass_writes (+1 if a write coincides with the last read), reads_left <= that
//   value, pass_writes <= 0.
//   same_cnt reaching STALL_PASSES sets stall (sticky). Tracking is frozen outside SOLVE.
//  pass_count saturates at all-ones.
// CONFIGURATION
//  OPTFIFO_HWM_EN defined: adds out port hwm [$clog2(DEPTH+1)], max occupancy since rst,
//   updated the cycle after occupancy.
//  OPTFIFO_HWM_EN undefined: no hwm port and no logic.
// STRUCTURE
//  nonogram_pkg: phase_t enum (IDLE/LOAD/SOLVE/DRAIN), OPT_WIDTH=16, FIFO_DEPTH.
//  Sub-module pass_tracker: pass_len / reads_left / pass_writes / same_cnt, stall and
//   pass_count. The top holds the FSM, mux, gating and occupancy.
// TESTING
//  1 Reset, then 5 parse_wr (din 0x0001..0x0005), then board_parsed -> fifo_wr_en 5 cycles,
//    occupancy=5, phase=SOLVE.
//  2 SOLVE: 5 pops with 3 put-backs -> pass_count=1, occupancy=3, stall=0.
//  3 Two further passes of 3 pops and 3 put-backs each -> stall=1 when the 2nd equal pass
//    completes (STALL_PASSES=2).
//  4 Hold fifo_full=1 during parse_wr -> fifo_wr_en=0, overflow_err=1, occupancy unchanged.
//  5 Same-cycle solve_rd and solve_wr with occupancy=3 -> occupancy stays 3.
//    Pop with fifo_empty=1 -> fifo_rd_en=0.
//  6 rst asserted mid-SOLVE -> next cycle phase=IDLE, counters=0, sticky flags=0;
//    with OPTFIFO_HWM_EN, hwm equals peak occupancy before rst, then 0.

Source files
------------

// File: rtl/nonogram_pkg.sv
// Shared types and defaults for the option FIFO scheduler.
package nonogram_pkg;

  localparam int unsigned OPT_WIDTH  = 16;
  localparam int unsigned FIFO_DEPTH = 1024;

  typedef enum logic [1:0] {
    PhaseIdle  = 2'd0,
    PhaseLoad  = 2'd1,
    PhaseSolve = 2'd2,
    PhaseDrain = 2'd3
  } phase_t;

endpackage

// File: rtl/pass_tracker.sv
// Counts solver passes over the option FIFO and raises a sticky stall flag
// once STALL_PASSES consecutive passes put back as many words as they consumed.
module pass_tracker #(
  parameter int unsigned PASS_W       = 16,
  parameter int unsigned STALL_PASSES = 2,
  parameter int unsigned OCC_W        = 11
) (
  input  logic              clk_100mhz,
  input  logic              rst,
  input  logic              solve_entry,
  input  logic [OCC_W-1:0]  entry_occ,
  input  logic              active,
  input  logic              rd_acc,
  input  logic              wr_acc,
  output logic [PASS_W-1:0] pass_count,
  output logic              stall
);

  logic [PASS_W-1:0] pass_len_q, pass_len_d;
  logic [PASS_W-1:0] reads_left_q, reads_left_d;
  logic [PASS_W-1:0] pass_writes_q, pass_writes_d;
  logic [PASS_W-1:0] same_cnt_q, same_cnt_d;
  logic [PASS_W-1:0] pass_count_q, pass_count_d;
  logic              stall_q, stall_d;

  logic [PASS_W-1:0] entry_len;
  logic [PASS_W-1:0] writes_total;
  logic              pass_done;

  assign entry_len    = PASS_W'(entry_occ);
  // A put-back in the same cycle as the pass's last read still belongs to that pass.
  assign writes_total = pass_writes_q + PASS_W'(wr_acc);
  assign pass_done    = active & rd_acc & (reads_left_q == PASS_W'(1));

  always_comb begin
    pass_len_d    = pass_len_q;
    reads_left_d  = reads_left_q;
    pass_writes_d = pass_writes_q;
    same_cnt_d    = same_cnt_q;
    pass_count_d  = pass_count_q;
    if (solve_entry) begin
      pass_len_d    = entry_len;
      reads_left_d  = entry_len;
      pass_writes_d = '0;
    end else if (active) begin
      if (pass_done) begin
        pass_count_d = (pass_count_q == '1) ? pass_count_q : pass_count_q + PASS_W'(1);
        if (writes_total == pass_len_q) begin
          same_cnt_d = (same_cnt_q == '1) ? same_cnt_q : same_cnt_q + PASS_W'(1);
        end else begin
          same_cnt_d = '0;
        end
        pass_len_d    = writes_total;
        reads_left_d  = writes_total;
        pass_writes_d = '0;
      end else begin
        if (rd_acc && (reads_left_q != '0)) begin
          reads_left_d = reads_left_q - PASS_W'(1);
        end
        if (wr_acc) begin
          pass_writes_d = writes_total;
        end
      end
    end
    stall_d = stall_q | (same_cnt_d >= PASS_W'(STALL_PASSES));
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      pass_len_q    <= '0;
      reads_left_q  <= '0;
      pass_writes_q <= '0;
      same_cnt_q    <= '0;
      pass_count_q  <= '0;
      stall_q       <= 1'b0;
    end else begin
      pass_len_q    <= pass_len_d;
      reads_left_q  <= reads_left_d;
      pass_writes_q <= pass_writes_d;
      same_cnt_q    <= same_cnt_d;
      pass_count_q  <= pass_count_d;
      stall_q       <= stall_d;
    end
  end

  assign pass_count = pass_count_q;
  assign stall      = stall_q;

endmodule

// File: rtl/option_fifo_sched.sv
// Phase sequencer, write-port mux and occupancy keeper for the shared option FIFO.
// Define OPTFIFO_HWM_EN to add the hwm (occupancy high-water mark) output.
module option_fifo_sched
  import nonogram_pkg::*;
#(
  parameter int unsigned WIDTH        = OPT_WIDTH,
  parameter int unsigned DEPTH        = FIFO_DEPTH,
  parameter int unsigned PASS_W       = 16,
  parameter int unsigned STALL_PASSES = 2
) (
  input  logic                       clk_100mhz,
  input  logic                       rst,
  input  logic                       parse_wr,
  input  logic [WIDTH-1:0]           parse_din,
  input  logic                       board_parsed,
  input  logic                       solve_wr,
  input  logic [WIDTH-1:0]           solve_din,
  input  logic                       solve_rd,
  input  logic                       board_solved,
  input  logic                       assembled,
  input  logic                       fifo_full,
  input  logic                       fifo_empty,
  output logic                       fifo_wr_en,
  output logic [WIDTH-1:0]           fifo_din,
  output logic                       fifo_rd_en,
  output logic [1:0]                 phase,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [PASS_W-1:0]          pass_count,
  output logic                       stall,
  output logic                       overflow_err
`ifdef OPTFIFO_HWM_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0] hwm
`endif
);

  localparam int unsigned OccW = $clog2(DEPTH + 1);

  phase_t state_q, state_d;

  logic             granted_wr;
  logic [WIDTH-1:0] granted_din;
  logic             rd_allow;
  logic             wr_acc, rd_acc;
  logic [OccW-1:0]  occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             solve_entry;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      state_q <= PhaseIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PhaseIdle:  if (parse_wr)     state_d = PhaseLoad;
      PhaseLoad:  if (board_parsed) state_d = PhaseSolve;
      PhaseSolve: if (board_solved) state_d = PhaseDrain;
      PhaseDrain: if (assembled)    state_d = PhaseIdle;
    endcase
  end

  // IDLE already grants the parser so the word that starts LOAD is not lost.
  always_comb begin
    granted_wr  = 1'b0;
    granted_din = '0;
    rd_allow    = 1'b0;
    unique case (state_q)
      PhaseIdle, PhaseLoad: begin
        granted_wr  = parse_wr;
        granted_din = parse_din;
      end
      PhaseSolve: begin
        granted_wr  = solve_wr;
        granted_din = solve_din;
        rd_allow    = 1'b1;
      end
      PhaseDrain: begin
        granted_wr = 1'b0;
      end
    endcase
  end

  assign wr_acc     = granted_wr & ~fifo_full;
  assign rd_acc     = solve_rd & ~fifo_empty & rd_allow;
  assign fifo_wr_en = wr_acc;
  assign fifo_din   = granted_din;
  assign fifo_rd_en = rd_acc;
  assign phase      = state_q;

  always_comb begin
    occ_d = occ_q;
    if (wr_acc && !rd_acc && (occ_q != OccW'(DEPTH))) begin
      occ_d = occ_q + OccW'(1);
    end else if (rd_acc && !wr_acc && (occ_q != '0)) begin
      occ_d = occ_q - OccW'(1);
    end
    ovf_d = ovf_q | (granted_wr & fifo_full);
  end

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      ovf_q <= ovf_d;
    end
  end

  assign occupancy    = occ_q;
  assign overflow_err = ovf_q;

  // Pass length is sampled from next-cycle occupancy so a write coincident
  // with board_parsed is counted in the first pass.
  assign solve_entry = (state_q == PhaseLoad) & board_parsed;

  pass_tracker #(
    .PASS_W      (PASS_W),
    .STALL_PASSES(STALL_PASSES),
    .OCC_W       (OccW)
  ) u_pass_tracker (
    .clk_100mhz (clk_100mhz),
    .rst        (rst),
    .solve_entry(solve_entry),
    .entry_occ  (occ_d),
    .active     (state_q == PhaseSolve),
    .rd_acc     (rd_acc),
    .wr_acc     (wr_acc),
    .pass_count (pass_count),
    .stall      (stall)
  );

`ifdef OPTFIFO_HWM_EN
  logic [OccW-1:0] hwm_q;

  always_ff @(posedge clk_100mhz) begin
    if (rst) begin
      hwm_q <= '0;
    end else if (occ_q > hwm_q) begin
      hwm_q <= occ_q;
    end
  end

  assign hwm = hwm_q;
`endif

endmodule

// File: tb/tb_option_fifo_sched.sv
// Self-checking bench for option_fifo_sched against a queue-based FIFO and pass model.
module tb_option_fifo_sched;

  localparam int unsigned W  = 16;
  localparam int unsigned D  = 16;
  localparam int unsigned PW = 16;
  localparam int unsigned SP = 2;
  localparam int unsigned OW = $clog2(D + 1);

  logic          clk_100mhz = 1'b0;
  logic          rst = 1'b1;
  logic          parse_wr = 1'b0, board_parsed = 1'b0, solve_wr = 1'b0, solve_rd = 1'b0;
  logic          board_solved = 1'b0, assembled = 1'b0, fifo_full = 1'b0, fifo_empty = 1'b1;
  logic [W-1:0]  parse_din = '0, solve_din = '0;
  logic          fifo_wr_en, fifo_rd_en, stall, overflow_err;
  logic [W-1:0]  fifo_din;
  logic [1:0]    phase;
  logic [OW-1:0] occupancy;
  logic [PW-1:0] pass_count;
`ifdef OPTFIFO_HWM_EN
  logic [OW-1:0] hwm;
`endif

  always #5 clk_100mhz = ~clk_100mhz;

  option_fifo_sched #(
    .WIDTH(W), .DEPTH(D), .PASS_W(PW), .STALL_PASSES(SP)
  ) dut (
    .clk_100mhz(clk_100mhz), .rst(rst),
    .parse_wr(parse_wr), .parse_din(parse_din), .board_parsed(board_parsed),
    .solve_wr(solve_wr), .solve_din(solve_din), .solve_rd(solve_rd),
    .board_solved(board_solved), .assembled(assembled),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_din(fifo_din), .fifo_rd_en(fifo_rd_en),
    .phase(phase), .occupancy(occupancy), .pass_count(pass_count),
    .stall(stall), .overflow_err(overflow_err)
`ifdef OPTFIFO_HWM_EN
    , .hwm(hwm)
`endif
  );

  // Reference state: FIFO contents as a queue, phase as a number, per-pass bookkeeping.
  logic [W-1:0] q[$];
  int  m_phase, m_pass_len, m_reads_left, m_pass_writes, m_same, m_pass_count, m_hwm;
  bit  m_stall, m_ovf, force_full, force_empty;
  int  n_pass = 0, n_total = 0;

  task automatic model_reset();
    q.delete();
    m_phase = 0; m_pass_len = 0; m_reads_left = 0; m_pass_writes = 0;
    m_same = 0; m_pass_count = 0; m_hwm = 0; m_stall = 0; m_ovf = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One pass ends when every word present at its start has been read back.
  task automatic track(input bit rd, input bit wr);
    if (wr) m_pass_writes++;
    if (rd && m_reads_left > 0) begin
      m_reads_left--;
      if (m_reads_left == 0) begin
        if (m_pass_count < 65535) m_pass_count++;
        m_same = (m_pass_writes == m_pass_len) ? m_same + 1 : 0;
        if (m_same >= SP) m_stall = 1;
        m_pass_len    = m_pass_writes;
        m_reads_left  = m_pass_writes;
        m_pass_writes = 0;
      end
    end
  endtask

  task automatic tick();
    bit full, empty, gwr, exp_wr, exp_rd;
    logic [W-1:0] gdin;
    full  = (q.size() >= D) || force_full;
    empty = (q.size() == 0) || force_empty;
    fifo_full  = full;
    fifo_empty = empty;
    gwr = 0; gdin = '0;
    if (m_phase <= 1) begin gwr = parse_wr; gdin = parse_din; end
    else if (m_phase == 2) begin gwr = solve_wr; gdin = solve_din; end
    exp_wr = gwr && !full;
    exp_rd = solve_rd && !empty && (m_phase == 2);
    #1;
    check("fifo_wr_en", 32'(fifo_wr_en), 32'(exp_wr));
    if (gwr) check("fifo_din", 32'(fifo_din), 32'(gdin));
    check("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
    check("phase", 32'(phase), 32'(m_phase));
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("pass_count", 32'(pass_count), 32'(m_pass_count));
    check("stall", 32'(stall), 32'(m_stall));
    check("overflow_err", 32'(overflow_err), 32'(m_ovf));
`ifdef OPTFIFO_HWM_EN
    check("hwm", 32'(hwm), 32'(m_hwm));
`endif
    @(posedge clk_100mhz);
    if (rst) begin
      model_reset();
    end else begin
      if (q.size() > m_hwm) m_hwm = q.size();
      if (exp_rd) void'(q.pop_front());
      if (exp_wr) q.push_back(gdin);
      if (gwr && full) m_ovf = 1;
      if (m_phase == 2) track(exp_rd, exp_wr);
      case (m_phase)
        0: if (parse_wr) m_phase = 1;
        1: if (board_parsed) begin
             m_phase = 2;
             m_pass_len = q.size(); m_reads_left = q.size(); m_pass_writes = 0;
           end
        2: if (board_solved) m_phase = 3;
        default: if (assembled) m_phase = 0;
      endcase
    end
    @(negedge clk_100mhz);
  endtask

  task automatic step(input bit pw, input logic [W-1:0] pd, input bit bp, input bit sw,
                      input logic [W-1:0] sd, input bit sr, input bit bs, input bit as);
    parse_wr = pw; parse_din = pd; board_parsed = bp;
    solve_wr = sw; solve_din = sd; solve_rd = sr;
    board_solved = bs; assembled = as;
    tick();
  endtask

  initial begin
    model_reset();
    force_full = 0; force_empty = 0;
    repeat (2) @(posedge clk_100mhz);
    @(negedge clk_100mhz);
    step(0, 0, 0, 0, 0, 0, 0, 0);  // still in reset: checks reset values
    rst = 1'b0;

    // Load five words, then enter SOLVE.
    for (int i = 1; i <= 5; i++) step(1, W'(i), 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // First pass: 5 pops, 3 put-backs.
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, W'(16'h10 + i), 1, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Two equal passes of 3 -> stall.
    for (int p = 0; p < 2; p++)
      for (int i = 0; i < 3; i++) step(0, 0, 0, 1, W'($urandom), 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Pop while the FIFO reports empty is ignored.
    force_empty = 1;
    step(0, 0, 0, 0, 0, 1, 0, 0);
    force_empty = 0;

    // DRAIN grants nobody, then back to IDLE.
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 16'hbeef, 0, 1, 16'h1234, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Write while full is dropped and flagged.
    force_full = 1;
    step(1, 16'h00aa, 0, 0, 0, 0, 0, 0);
    step(1, 16'h00bb, 0, 0, 0, 0, 0, 0);
    force_full = 0;
    step(0, 0, 1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1);

    // Randomised load/solve rounds.
    for (int r = 0; r < 3; r++) begin
      step(1, W'($urandom), 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1'($urandom), W'($urandom), 0, 0, 0, 0, 0, 0);
      step(1'($urandom), W'($urandom), 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < 250; i++) begin
        force_full  = ($urandom_range(0, 19) == 0);
        force_empty = ($urandom_range(0, 19) == 0);
        step(1'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 99) < 45,
             W'($urandom), $urandom_range(0, 99) < 55, 0, 1'($urandom));
      end
      force_full = 0; force_empty = 0;
      step(0, 0, 0, 0, 0, 0, 1, 0);
      step(0, 0, 0, 0, 0, 0, 0, 1);
    end

    // Reset in the middle of SOLVE.
    for (int i = 0; i < 4; i++) step(1, W'($urandom), 0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1'($urandom), W'($urandom), 1'($urandom), 0, 0);
    rst = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
